rob_ctrl: RTL and testbench
===========================

Name: rob_ctrl

Overview:
- Control stage wrapped around the 16-entry reorder-buffer storage array.
- Issues transaction tags to the upstream requester and steers out-of-order responses into storage at their tag address.
- Drains storage strictly in tag-allocation order to a downstream valid/ready consumer.
- Owns allocation and retire pointers, occupancy, and protocol-error detection. Storage owns data and per-entry valid bits.

Parameters:
- DEPTH, 16, number of tags/entries; power of two; must match storage depth.
- DATA_W, 8, response payload width; must match storage width.
- AW, $clog2(DEPTH) = 4, local/derived, tag and address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  upstream requests a tag.
- req_ready_o  out  1  tag available: count < DEPTH.
- req_tag_o  out  AW  tag granted on req fire; equals alloc_ptr.
- rsp_valid_i  in  1  response arriving from interconnect.
- rsp_ready_o  out  1  response accepted this cycle.
- rsp_tag_i  in  AW  tag of the response.
- rsp_data_i  in  DATA_W  response payload.
- mem_we_o  out  1  storage write enable.
- mem_waddr_o  out  AW  storage write address, equal to rsp_tag_i.
- mem_wdata_o  out  DATA_W  storage write data, equal to rsp_data_i.
- mem_re_o  out  1  storage read/consume, which clears the head valid bit.
- mem_raddr_o  out  AW  storage read address, equal to ret_ptr.
- mem_data_i  in  DATA_W  storage combinational read data at mem_raddr_o.
- mem_valid_i  in  1  storage valid bit at mem_raddr_o.
- out_valid_o  out  1  in-order head entry ready for downstream.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  head payload (passes mem_data_i through).
- count_o  out  AW+1  outstanding tags, 0..DEPTH.
- err_o  out  1  sticky protocol error.

Behaviour:
- State registers:
  - alloc_ptr (AW bits), ret_ptr (AW bits), count (AW+1 bits), err (1 bit).
  - All are 0 on rst; rst is the same signal that clears the storage valid bits.
- Reset outputs: req_ready_o=1, req_tag_o=0, out_valid_o=0, rsp_ready_o=1, mem_we_o=0, mem_re_o=0, count_o=0, err_o=0.
- Allocation:
  - req_fire = req_valid_i & (count < DEPTH).
  - On req_fire, alloc_ptr increments and wraps DEPTH-1 -> 0.
  - req_tag_o is valid combinationally in the fire cycle.
- Retire:
  - out_valid_o = (count != 0) & mem_valid_i.
  - pop = out_valid_o & out_ready_i.
  - mem_re_o = pop.
  - On pop, ret_ptr increments and wraps.
  - out_data_o = mem_data_i, combinational with zero added latency.
- Response path and write/read conflict:
  - Storage ignores a read-clear in a cycle where it is written, so retire takes priority.
  - rsp_ready_o = ~pop. This is a combinational path from out_ready_i; it is intentional.
  - rsp_fire = rsp_valid_i & rsp_ready_o.
  - mem_we_o = rsp_fire & tag_live.
  - tag_live = ((rsp_tag_i - ret_ptr) mod DEPTH) < count.
- Invalid tag:
  - A response with ~tag_live is accepted (rsp_ready_o unchanged), dropped with no write, and sets err.
  - err is cleared only by rst.
- Latency: a response written to the head tag in cycle N produces out_valid_o=1 in cycle N+1.
- Count update:
  - +1 on req_fire & ~pop.
  - -1 on pop & ~req_fire.
  - Unchanged when both or neither occur.
- Full (count=DEPTH):
  - req_ready_o=0.
  - A simultaneous pop does not admit a request that same cycle; ready is computed from the registered count.
- Empty (count=0): out_valid_o=0 regardless of mem_valid_i.
- Wrap: alloc_ptr == ret_ptr is disambiguated by count; both the full and the empty case must work.
- Duplicate response to a live, already-written tag: overwrites the entry, no error (not detectable here).
- Reset mid-operation:
  - Every outstanding tag is abandoned.
  - Late responses then fail tag_live (count=0) and raise err_o.

Decomposition:
- Package rob_pkg holds:
  - localparams ROB_DEPTH=16, ROB_DATA_W=8, ROB_AW=4;
  - typedef rob_tag_t (logic [ROB_AW-1:0]);
  - typedef rob_cnt_t (logic [ROB_AW:0]).
- One natural sub-module: rob_ptr_ctr, a wrap-around pointer with an increment enable, instantiated twice (alloc and retire).
- The storage array is instantiated by the parent, not inside rob_ctrl.

Test Plan:
1. Reset, then 3 requests back-to-back -> tags 0,1,2; count_o=3; out_valid_o=0.
2. Responses arrive in order tag2(0xC2), tag0(0xA0), tag1(0xB1) -> out_data_o sequence 0xA0, 0xB1, 0xC2; 0xA0 appears the cycle after the tag0 write; count_o returns to 0.
3. Fill 16 tags -> req_ready_o=0 at count 16. Respond to all, pop one -> count 15 and req_ready_o=1 next cycle. Continue 20 more alloc/retire pairs -> tags wrap 15->0, data stays in order.
4. Head valid, out_ready_i=1, rsp_valid_i=1 in the same cycle -> rsp_ready_o=0, mem_we_o=0. Response is accepted the following cycle and written.
5. Response with tag 5 while only tags 0..1 are outstanding -> mem_we_o=0, rsp_ready_o=1, err_o=1 from the next cycle and sticky.
6. 4 tags outstanding, assert rst for 1 cycle -> count_o=0, out_valid_o=0, req_tag_o=0. A later response with tag 2 -> err_o=1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared sizing and type definitions for the reorder-buffer control slice.
package rob_pkg;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_DATA_W = 8;
  localparam int ROB_AW     = 4;

  typedef logic [ROB_AW-1:0] rob_tag_t;
  typedef logic [ROB_AW:0]   rob_cnt_t;
endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrap-around pointer: advances by one on inc and wraps naturally at 2**AW.
module rob_ptr_ctr
  import rob_pkg::*;
#(
  parameter int AW = ROB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // Pointer register; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: hands out tags, steers responses into storage by tag,
// and drains storage strictly in allocation order to a valid/ready consumer.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter  int DEPTH  = ROB_DEPTH,
  parameter  int DATA_W = ROB_DATA_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [AW-1:0]     req_tag_o,
  input  logic              rsp_valid_i,
  output logic              rsp_ready_o,
  input  logic [AW-1:0]     rsp_tag_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic [AW-1:0]     mem_raddr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_valid_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [AW:0]       count_o,
  output logic              err_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] alloc_ptr;
  logic [AW-1:0] ret_ptr;
  logic [AW-1:0] tag_dist;
  logic [AW:0]   count;
  logic          err;
  logic          req_fire;
  logic          pop;
  logic          rsp_fire;
  logic          tag_live;

  // Admission uses the registered count, so a pop never frees a slot in the same cycle.
  assign req_ready_o = count < FULL;
  assign req_fire    = req_valid_i & req_ready_o;
  assign req_tag_o   = alloc_ptr;

  // Head is presentable only when something is outstanding and storage holds it.
  assign out_valid_o = (count != '0) & mem_valid_i;
  assign pop         = out_valid_o & out_ready_i;
  assign mem_re_o    = pop;
  assign mem_raddr_o = ret_ptr;
  assign out_data_o  = mem_data_i;

  // Storage cannot write and clear in one cycle, so a retiring cycle stalls responses.
  assign rsp_ready_o = ~pop;
  assign rsp_fire    = rsp_valid_i & rsp_ready_o;

  // A tag is live when its distance from the retire pointer lies inside the window.
  assign tag_dist    = rsp_tag_i - ret_ptr;
  assign tag_live    = {1'b0, tag_dist} < count;
  assign mem_we_o    = rsp_fire & tag_live;
  assign mem_waddr_o = rsp_tag_i;
  assign mem_wdata_o = rsp_data_i;

  assign count_o = count;
  assign err_o   = err;

  rob_ptr_ctr #(.AW(AW)) u_alloc_ptr (
    .clk (clk),
    .rst (rst),
    .inc (req_fire),
    .ptr (alloc_ptr)
  );

  rob_ptr_ctr #(.AW(AW)) u_ret_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (ret_ptr)
  );

  // Occupancy: a simultaneous allocate and retire leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (req_fire & ~pop) begin
      count <= count + (AW+1)'(1);
    end else if (pop & ~req_fire) begin
      count <= count - (AW+1)'(1);
    end
  end

  // Sticky error for any accepted response whose tag is not outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (rsp_fire & ~tag_live) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: behavioural storage array plus an ordered-queue reference model.
module tb_rob_ctrl;
  import rob_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  rob_tag_t   req_tag;
  logic       rsp_valid;
  logic       rsp_ready;
  rob_tag_t   rsp_tag;
  logic [7:0] rsp_data;
  logic       mem_we;
  rob_tag_t   mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_re;
  rob_tag_t   mem_raddr;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  rob_cnt_t   count;
  logic       err;

  always #5 clk = ~clk;

  rob_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_tag_o   (req_tag),
    .rsp_valid_i (rsp_valid),
    .rsp_ready_o (rsp_ready),
    .rsp_tag_i   (rsp_tag),
    .rsp_data_i  (rsp_data),
    .mem_we_o    (mem_we),
    .mem_waddr_o (mem_waddr),
    .mem_wdata_o (mem_wdata),
    .mem_re_o    (mem_re),
    .mem_raddr_o (mem_raddr),
    .mem_data_i  (mem_data),
    .mem_valid_i (mem_valid),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .count_o     (count),
    .err_o       (err)
  );

  // Storage array stand-in: data plus per-entry valid, cleared by rst.
  logic [7:0] st_data [16];
  logic       st_vld  [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) st_vld[i] <= 1'b0;
    end else begin
      if (mem_we) begin
        st_data[mem_waddr] <= mem_wdata;
        st_vld[mem_waddr]  <= 1'b1;
      end
      if (mem_re && !(mem_we && mem_waddr == mem_raddr)) st_vld[mem_raddr] <= 1'b0;
    end
  end

  assign mem_data  = st_data[mem_raddr];
  assign mem_valid = st_vld[mem_raddr];

  // Reference model: outstanding tags in allocation order, responded payloads by tag.
  int         q[$];
  bit         have [16];
  logic [7:0] val  [16];
  int         next_tag;
  bit         merr;
  bit         p_pop, p_we, p_req, p_bad;
  int         l_tag;
  logic [7:0] l_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 16; i++) have[i] = 1'b0;
    next_tag = 0;
    merr = 1'b0;
  endtask

  // Drive one cycle of inputs, let them settle, and compare every output to the model.
  task automatic apply(input bit rv, input bit sv, input int t, input logic [7:0] d, input bit ordy);
    int  cnt;
    bit  live, ov;
    req_valid = rv;
    rsp_valid = sv;
    rsp_tag   = rob_tag_t'(t);
    rsp_data  = d;
    out_ready = ordy;
    #3;
    cnt  = q.size();
    live = 1'b0;
    foreach (q[i]) if (q[i] == t) live = 1'b1;
    ov    = (cnt > 0) && have[q[0]];
    p_pop = ov && ordy;
    p_we  = sv && !p_pop && live;
    p_bad = sv && !p_pop && !live;
    p_req = rv && (cnt < 16);
    l_tag  = t;
    l_data = d;
    chk("req_ready", int'(req_ready), int'(cnt < 16));
    chk("req_tag", int'(req_tag), next_tag);
    chk("out_valid", int'(out_valid), int'(ov));
    if (ov) chk("out_data", int'(out_data), int'(val[q[0]]));
    chk("rsp_ready", int'(rsp_ready), int'(!p_pop));
    chk("mem_we", int'(mem_we), int'(p_we));
    if (p_we) begin
      chk("mem_waddr", int'(mem_waddr), t);
      chk("mem_wdata", int'(mem_wdata), int'(d));
    end
    chk("mem_re", int'(mem_re), int'(p_pop));
    chk("mem_raddr", int'(mem_raddr), (cnt > 0) ? q[0] : next_tag);
    chk("count", int'(count), cnt);
    chk("err", int'(err), int'(merr));
  endtask

  // Clock edge, then advance the model by the events predicted for that cycle.
  task automatic advance();
    @(posedge clk);
    if (p_we) begin
      have[l_tag] = 1'b1;
      val[l_tag]  = l_data;
    end
    if (p_bad) merr = 1'b1;
    if (p_pop) begin
      have[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (p_req) begin
      q.push_back(next_tag);
      next_tag = (next_tag + 1) % 16;
    end
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
    rsp_tag = '0; rsp_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit         rv, sv;
    int         stag;
    logic [7:0] sdata;
    bit         ordy;
    bit         e_rr;
    int         e_tag;
    bit         e_ov;
    logic [7:0] e_od;
    bit         e_rspr, e_we;
    int         e_cnt;
    bit         e_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int         tags[16];
    int         tmp, j, nt, pick;
    logic [7:0] d;
    rst = 1'b1;
    req_valid = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
    rsp_tag = '0; rsp_data = '0;
    model_clear();

    //          rv sv tag data   ordy rr tag ov od     rspr we cnt err
    vecs[0]  = '{0, 0, 0, 8'h00, 0,   1, 0,  0, 8'h00, 1,   0, 0,  0};
    vecs[1]  = '{1, 0, 0, 8'h00, 0,   1, 0,  0, 8'h00, 1,   0, 0,  0};
    vecs[2]  = '{1, 0, 0, 8'h00, 0,   1, 1,  0, 8'h00, 1,   0, 1,  0};
    vecs[3]  = '{1, 0, 0, 8'h00, 0,   1, 2,  0, 8'h00, 1,   0, 2,  0};
    vecs[4]  = '{0, 1, 2, 8'hC2, 0,   1, 3,  0, 8'h00, 1,   1, 3,  0};
    vecs[5]  = '{0, 1, 0, 8'hA0, 0,   1, 3,  0, 8'h00, 1,   1, 3,  0};
    vecs[6]  = '{0, 1, 1, 8'hB1, 0,   1, 3,  1, 8'hA0, 1,   1, 3,  0};
    vecs[7]  = '{0, 0, 0, 8'h00, 1,   1, 3,  1, 8'hA0, 0,   0, 3,  0};
    vecs[8]  = '{0, 0, 0, 8'h00, 1,   1, 3,  1, 8'hB1, 0,   0, 2,  0};
    vecs[9]  = '{0, 0, 0, 8'h00, 1,   1, 3,  1, 8'hC2, 0,   0, 1,  0};
    vecs[10] = '{0, 0, 0, 8'h00, 1,   1, 3,  0, 8'h00, 1,   0, 0,  0};

    reset_dut();

    // Basic allocate / out-of-order respond / in-order drain.
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].rv, vecs[i].sv, vecs[i].stag, vecs[i].sdata, vecs[i].ordy);
      chk($sformatf("v%0d_req_ready", i), int'(req_ready), int'(vecs[i].e_rr));
      chk($sformatf("v%0d_req_tag", i), int'(req_tag), vecs[i].e_tag);
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("v%0d_out_data", i), int'(out_data), int'(vecs[i].e_od));
      chk($sformatf("v%0d_rsp_ready", i), int'(rsp_ready), int'(vecs[i].e_rspr));
      chk($sformatf("v%0d_mem_we", i), int'(mem_we), int'(vecs[i].e_we));
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].e_cnt);
      chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].e_err));
      advance();
    end

    // Fill to full, respond in shuffled order, then pop with a blocked request.
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b0, 0, 8'h00, 1'b0);
      advance();
    end
    apply(1'b1, 1'b0, 0, 8'h00, 1'b0);
    chk("full_req_ready", int'(req_ready), 0);
    chk("full_count", int'(count), 16);
    advance();
    foreach (q[i]) tags[i] = q[i];
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = tags[i]; tags[i] = tags[j]; tags[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, tags[i], 8'(tags[i] * 7 + 3), 1'b0);
      advance();
    end
    apply(1'b1, 1'b0, 0, 8'h00, 1'b1);
    chk("full_pop_no_admit", int'(req_ready), 0);
    chk("full_pop_out_valid", int'(out_valid), 1);
    advance();
    idle();
    chk("after_pop_count", int'(count), 15);
    chk("after_pop_req_ready", int'(req_ready), 1);
    advance();
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b0, 0, 8'h00, 1'b1);
      advance();
      apply(1'b0, 1'b1, q[q.size()-1], 8'($urandom_range(0, 255)), 1'b0);
      advance();
    end

    // Retire/response collision: response stalls one cycle, then writes.
    apply(1'b1, 1'b0, 0, 8'h00, 1'b0);
    nt = next_tag;
    advance();
    apply(1'b0, 1'b1, nt, 8'h5A, 1'b1);
    chk("collide_rsp_ready", int'(rsp_ready), 0);
    chk("collide_mem_we", int'(mem_we), 0);
    advance();
    apply(1'b0, 1'b1, nt, 8'h5A, 1'b0);
    chk("retry_rsp_ready", int'(rsp_ready), 1);
    chk("retry_mem_we", int'(mem_we), 1);
    advance();

    // Response to a tag that is not outstanding.
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 0, 8'h00, 1'b0);
      advance();
    end
    apply(1'b0, 1'b1, 5, 8'h55, 1'b0);
    chk("bad_tag_we", int'(mem_we), 0);
    chk("bad_tag_rsp_ready", int'(rsp_ready), 1);
    chk("bad_tag_err_same", int'(err), 0);
    advance();
    idle();
    chk("bad_tag_err_next", int'(err), 1);
    advance();
    for (int i = 0; i < 3; i++) begin
      idle();
      advance();
    end
    idle();
    chk("bad_tag_err_sticky", int'(err), 1);
    advance();

    // Reset with tags outstanding abandons them.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 0, 8'h00, 1'b0);
      advance();
    end
    idle();
    chk("pre_rst_count", int'(count), 4);
    advance();
    reset_dut();
    idle();
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_req_tag", int'(req_tag), 0);
    chk("rst_err", int'(err), 0);
    advance();
    apply(1'b0, 1'b1, 2, 8'h22, 1'b0);
    chk("late_rsp_we", int'(mem_we), 0);
    advance();
    idle();
    chk("late_rsp_err", int'(err), 1);
    advance();

    // Randomized traffic, mostly to live tags, with occasional resets.
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_dut();
      end else begin
        if (q.size() > 0 && $urandom_range(0, 99) < 90) pick = q[$urandom_range(0, q.size() - 1)];
        else pick = int'($urandom_range(0, 15));
        d = 8'($urandom_range(0, 255));
        apply($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60, pick, d,
              $urandom_range(0, 99) < 55);
        advance();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
